sc_obc_axil_regif: RTL

//  AXI4-Lite responder (slave) in the PL fabric, addressed by the Versal PS master through the NoC/PL AXI port.

---
 rtl/sc_obc_axil_pkg.sv | 23 ++
 rtl/sc_obc_axil_regfile.sv | 105 ++++++++++
 rtl/sc_obc_axil_regif.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sc_obc_axil_pkg.sv
// sc_obc_axil_pkg: shared AXI4-Lite response codes, register offsets and channel FSM state types.
package sc_obc_axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] OFF_VERSION = 32'h000;
    localparam logic [31:0] OFF_STATUS  = 32'h004;
    localparam logic [31:0] OFF_SCRATCH = 32'h010;
    localparam logic [31:0] OFF_TS_LO   = 32'h040;
    localparam logic [31:0] OFF_TS_HI   = 32'h044;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
endpackage

// File: rtl/sc_obc_axil_regfile.sv
// sc_obc_axil_regfile: address decode, scratch storage, error counter and (with SC_OBC_AXIL_TIMESTAMP_EN) a 64-bit timestamp.
module sc_obc_axil_regfile
    import sc_obc_axil_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] VERSION     = VERSION_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    output logic [1:0]        wr_resp,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_resp
);
    logic [31:0] wa, ra;
    logic [31:0] scratch [NUM_SCRATCH];
    logic [NUM_SCRATCH-1:0] w_hit;
    logic [7:0] err_cnt;
    logic clr;
    logic [1:0] inc;

    assign wa = 32'({wr_addr[ADDR_W-1:2], 2'b00});
    assign ra = 32'({rd_addr[ADDR_W-1:2], 2'b00});

`ifdef SC_OBC_AXIL_TIMESTAMP_EN
    logic [63:0] ts;
    logic [31:0] ts_hi_snap;
    // Reading TS_LO freezes the upper half so a following TS_HI read forms a coherent pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            ts_hi_snap <= '0;
        end else begin
            ts <= ts + 64'd1;
            if (rd_en && ra == OFF_TS_LO) ts_hi_snap <= ts[63:32];
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_SCRATCH; i++) w_hit[i] = wa == OFF_SCRATCH + 32'(4 * i);
    end

    always_comb begin
        wr_resp = (|w_hit || wa == OFF_STATUS) ? RESP_OKAY : RESP_DECERR;
        if (wa == OFF_VERSION) wr_resp = RESP_SLVERR;
`ifdef SC_OBC_AXIL_TIMESTAMP_EN
        if (wa == OFF_TS_LO || wa == OFF_TS_HI) wr_resp = RESP_SLVERR;
`endif
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_DECERR;
        if (ra == OFF_VERSION) begin
            rd_data = VERSION;
            rd_resp = RESP_OKAY;
        end
        if (ra == OFF_STATUS) begin
            rd_data = {24'h0, err_cnt};
            rd_resp = RESP_OKAY;
        end
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (ra == OFF_SCRATCH + 32'(4 * i)) begin
                rd_data = scratch[i];
                rd_resp = RESP_OKAY;
            end
        end
`ifdef SC_OBC_AXIL_TIMESTAMP_EN
        if (ra == OFF_TS_LO) begin
            rd_data = ts[31:0];
            rd_resp = RESP_OKAY;
        end
        if (ra == OFF_TS_HI) begin
            rd_data = ts_hi_snap;
            rd_resp = RESP_OKAY;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                for (int b = 0; b < 4; b++)
                    if (w_hit[i] && wr_strb[b]) scratch[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // A B-side and an R-side error in the same cycle both count; a clear overrides either.
    assign clr = wr_en && wa == OFF_STATUS && wr_strb[0];
    assign inc = {1'b0, wr_en && wr_resp != RESP_OKAY} + {1'b0, rd_en && rd_resp != RESP_OKAY};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt <= '0;
        else err_cnt <= clr ? 8'h00 : sat_add(err_cnt, inc);
    end
endmodule

// File: rtl/sc_obc_axil_regif.sv
// sc_obc_axil_regif: AXI4-Lite register-file responder with independent write and read channel FSMs.
// Optional timestamp registers enabled by defining SC_OBC_AXIL_TIMESTAMP_EN.
module sc_obc_axil_regif
    import sc_obc_axil_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] VERSION     = VERSION_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic aw_done, w_done, aw_hs, w_hs, ar_hs, wr_fire;
    logic [ADDR_W-1:0] aw_q, wr_addr;
    logic [31:0] wdata_q, wr_data, rd_data;
    logic [3:0] wstrb_q, wr_strb;
    logic [1:0] wr_resp, rd_resp;

    assign S_AXI_AWREADY = w_state == W_IDLE && !aw_done;
    assign S_AXI_WREADY  = w_state == W_IDLE && !w_done;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_ARREADY = r_state == R_IDLE;
    assign S_AXI_RVALID  = r_state == R_RESP;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    // The last of AW/W may arrive this cycle, so bypass its latch.
    assign wr_fire = (aw_done || aw_hs) && (w_done || w_hs);
    assign wr_addr = aw_done ? aw_q : S_AXI_AWADDR;
    assign wr_data = w_done ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_done ? wstrb_q : S_AXI_WSTRB;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        if (w_state == W_IDLE && wr_fire) w_next = W_RESP;
        if (w_state == W_RESP && S_AXI_BREADY) w_next = W_IDLE;
        if (ar_hs) r_next = R_RESP;
        if (r_state == R_RESP && S_AXI_RREADY) r_next = R_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            aw_q        <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else begin
            if (wr_fire) begin
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                S_AXI_BRESP <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_done <= 1'b1;
                    aw_q    <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_done  <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
            end
            if (ar_hs) begin
                S_AXI_RDATA <= rd_data;
                S_AXI_RRESP <= rd_resp;
            end
        end
    end

    sc_obc_axil_regfile #(
        .ADDR_W(ADDR_W),
        .NUM_SCRATCH(NUM_SCRATCH),
        .VERSION(VERSION)
    ) u_regfile (
        .clk(CLK),
        .rst(RST),
        .wr_en(wr_fire),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .wr_resp(wr_resp),
        .rd_en(ar_hs),
        .rd_addr(S_AXI_ARADDR),
        .rd_data(rd_data),
        .rd_resp(rd_resp)
    );
endmodule
